bp_referee: RTL
===============

BP_REFEREE -- requirements
Module: bp_referee

Interface
REQ-001 Parameters (name, default, meaning): ROWS, 64, map rows sent per game; OBS_PERIOD, 8, obstacle-row spacing; TIMEOUT, 100, maximum cycles from last row sent to first move.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; rst, in, 1, reset, synchronous and active-high.
REQ-003 start, in, 1, one-cycle pulse that launches a game; seed, in, 16, LFSR seed, sampled on start.
REQ-004 bp_in_valid, out, 1, row valid to player; bp_guy, out, 3, start lane (first row only, else 0); bp_row, out, 16, lane i at bits [2i+1:2i] (0 empty, 1 low obstacle, 2 high obstacle, 3 wall).
REQ-005 out_valid, in, 1, player move valid; out, in, 2, move (00 stay, 01 right, 10 left, 11 jump).
REQ-006 busy, out, 1, game in progress; done, out, 1, one-cycle result pulse; pass, out, 1, result; err_code, out, 2, failure kind; fail_row, out, 6, row index of first failure.

Function
REQ-007 States: IDLE, SEND, WAIT, CHECK, DONE; busy is 1 in every state except IDLE.
REQ-008 IDLE->SEND on start; start outside IDLE is ignored.
REQ-009 LFSR: 16-bit Fibonacci, taps 16,14,13,11; loaded with seed on start, or with 16'hACE1 if seed is 0; advances once per SEND cycle.
REQ-010 SEND: bp_in_valid=1 for exactly ROWS consecutive cycles, starting the cycle after start; row k=0..ROWS-1.
REQ-011 Row 0: bp_row all zero, bp_guy=lfsr[2:0]. Rows where k mod OBS_PERIOD=0 and k>0: lane lfsr[2:0] carries type (lfsr[3]?2:1), all other lanes 3. All remaining rows are zero.
REQ-012 Obstacle lane and type are stored per obstacle row (7 entries of 5 bits); guy lane register initialised from bp_guy.
REQ-013 SEND->WAIT after row ROWS-1; WAIT->CHECK on the first out_valid=1; WAIT->DONE with err_code 0, fail_row 0 if TIMEOUT cycles elapse without out_valid.
REQ-014 CHECK: the cycle that takes WAIT->CHECK is move 1; move m moves the guy into row m, m=1..ROWS-1 (63 moves).
REQ-015 Move update: 01 adds 1 to lane, 10 subtracts 1, 00 and 11 keep lane.
REQ-016 Checks on move m, in priority order: 01 at lane 7 or 10 at lane 0 -> err 1 (out of bounds); obstacle row and new lane != opening -> err 2 (collision); opening type 1 and move != 11, or type 2 and move == 11 -> err 3 (wrong action). Jump on an empty row is legal.
REQ-017 out_valid=0 during CHECK before move 63 -> err 0, fail_row=m.
REQ-018 First error: CHECK->DONE the next cycle, pass=0, fail_row=m; later moves are not examined.
REQ-019 Move 63 error-free -> DONE the next cycle with pass=1, err_code=0, fail_row=0.
REQ-020 DONE lasts one cycle with done=1, then goes to IDLE; pass, err_code and fail_row hold until the next start, which clears them.
REQ-021 Player moves arriving in IDLE or DONE are ignored.

Reset
REQ-022 rst takes priority over all inputs; on the next clk edge: state IDLE, all outputs 0, LFSR 16'hACE1, counters 0.
REQ-023 rst mid-game aborts the game without a done pulse; bp_in_valid drops the same edge.

Structure
REQ-024 A shared package holds: state encoding; move codes (STAY, RIGHT, LEFT, JUMP); tile codes (EMPTY, LOW, HIGH, WALL); error codes (TIMEOUT/PROTOCOL=0, BOUNDS=1, COLLIDE=2, ACTION=3).
REQ-025 The LFSR is one sub-module, bp_lfsr (load, enable, 16-bit state).

Verification
REQ-026 Correct player, seed 16'h1234: 64-row map, 63 valid moves -> done=1, pass=1, err_code=0.
REQ-027 Start lane 0, first move 10 -> done, pass=0, err_code=1, fail_row=1.
REQ-028 Row 8 has a type-1 opening at lane 3; player reaches lane 3 but sends 00 at move 8 -> err_code=3, fail_row=8. Same player at lane 4 at move 8 -> err_code=2, fail_row=8.
REQ-029 No out_valid after SEND -> done exactly TIMEOUT cycles after the last row, err_code=0, fail_row=0; out_valid dropped at move 20 -> err_code=0, fail_row=20.
REQ-030 seed 0 -> map identical to seed 16'hACE1; start pulsed during SEND -> ignored, still 64 rows sent; rst at row 30 -> bp_in_valid=0 next cycle, no done pulse.

Source files
------------

// File: rtl/bp_referee_pkg.sv
// Shared definitions for the BP referee: FSM state encoding, player move codes,
// map tile codes, failure codes and the LFSR step function.
package bp_referee_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StCheck,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    MoveStay  = 2'd0,
    MoveRight = 2'd1,
    MoveLeft  = 2'd2,
    MoveJump  = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    TileEmpty = 2'd0,
    TileLow   = 2'd1,
    TileHigh  = 2'd2,
    TileWall  = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    ErrTimeout = 2'd0,
    ErrBounds  = 2'd1,
    ErrCollide = 2'd2,
    ErrAction  = 2'd3
  } err_e;

  // A missing move mid-game shares code 0 with the start-of-game timeout.
  localparam err_e ErrProtocol = ErrTimeout;

  localparam logic [15:0] LfsrReset = 16'hACE1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/bp_referee_lfsr.sv
// bp_lfsr: 16-bit map-generation LFSR.
//   clk, rst  : clock, synchronous active-high reset (state -> 16'hACE1)
//   load      : load load_val this cycle (takes priority over enable)
//   load_val  : value to load
//   enable    : advance one step
//   state     : current LFSR state
module bp_lfsr
  import bp_referee_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LfsrReset;
    end else if (load) begin
      state_q <= load_val;
    end else if (enable) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bp_referee.sv
// bp_referee: generates a pseudo-random lane map for a player, then referees
// the player's moves through it and reports pass/fail.
//   clk, rst             : clock, synchronous active-high reset
//   start, seed          : launch pulse (honoured in idle only), LFSR seed
//   bp_in_valid, bp_guy,
//   bp_row               : map row stream to the player (2 bits per lane)
//   out_valid, out       : player move (stay/right/left/jump)
//   busy, done           : game in progress, one-cycle result pulse
//   pass, err_code,
//   fail_row             : result, held until the next start
// Row/move counters are 6 bits wide, so ROWS must not exceed 64.
module bp_referee
  import bp_referee_pkg::*;
#(
  parameter int unsigned ROWS       = 64,
  parameter int unsigned OBS_PERIOD = 8,
  parameter int unsigned TIMEOUT    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        bp_in_valid,
  output logic [2:0]  bp_guy,
  output logic [15:0] bp_row,
  input  logic        out_valid,
  input  logic [1:0]  out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [5:0]  fail_row
);

  localparam int unsigned NumObs = (ROWS - 1) / OBS_PERIOD;
  localparam int unsigned WaitW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e                   state_q, state_d;
  logic [5:0]               row_q, row_d;
  logic [5:0]               move_q, move_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic [2:0]               lane_q, lane_d;
  // Per obstacle row: {opening lane, opening tile}.
  logic [NumObs-1:0][4:0]   obs_q, obs_d;
  logic                     pass_q, pass_d;
  err_e                     err_q, err_d;
  logic [5:0]               fail_q, fail_d;

  logic [15:0] lfsr;
  logic        lfsr_load, lfsr_en;
  logic        unused_lfsr_hi;

  bp_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val ((seed == 16'h0) ? LfsrReset : seed),
    .enable   (lfsr_en),
    .state    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:4];

  // Map row generation.
  logic  row_is_obs;
  tile_e obs_tile;

  always_comb begin
    row_is_obs = 1'b0;
    for (int i = 0; i < NumObs; i++) begin
      if (row_q == 6'((i + 1) * OBS_PERIOD)) row_is_obs = 1'b1;
    end
    obs_tile = lfsr[3] ? TileHigh : TileLow;
    bp_row   = '0;
    bp_guy   = '0;
    if (state_q == StSend) begin
      if (row_q == 6'd0) begin
        bp_guy = lfsr[2:0];
      end else if (row_is_obs) begin
        for (int j = 0; j < 8; j++) begin
          bp_row[2*j +: 2] = (3'(j) == lfsr[2:0]) ? obs_tile : TileWall;
        end
      end
    end
  end

  // Evaluation of the move presented this cycle, for row move_q.
  move_e      mv;
  logic       move_is_obs;
  logic [4:0] opening;
  logic [2:0] new_lane;
  logic       move_err;
  err_e       move_code;

  always_comb begin
    mv          = move_e'(out);
    move_is_obs = 1'b0;
    opening     = '0;
    for (int i = 0; i < NumObs; i++) begin
      if (move_q == 6'((i + 1) * OBS_PERIOD)) begin
        move_is_obs = 1'b1;
        opening     = obs_q[i];
      end
    end
    new_lane = lane_q;
    unique case (mv)
      MoveRight: new_lane = lane_q + 3'd1;
      MoveLeft:  new_lane = lane_q - 3'd1;
      default:   new_lane = lane_q;
    endcase
    move_err  = 1'b0;
    move_code = ErrTimeout;
    if ((mv == MoveRight && lane_q == 3'd7) || (mv == MoveLeft && lane_q == 3'd0)) begin
      move_err  = 1'b1;
      move_code = ErrBounds;
    end else if (move_is_obs && new_lane != opening[4:2]) begin
      move_err  = 1'b1;
      move_code = ErrCollide;
    end else if (move_is_obs &&
                 ((tile_e'(opening[1:0]) == TileLow && mv != MoveJump) ||
                  (tile_e'(opening[1:0]) == TileHigh && mv == MoveJump))) begin
      move_err  = 1'b1;
      move_code = ErrAction;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    move_d    = move_q;
    wait_d    = wait_q;
    lane_d    = lane_q;
    obs_d     = obs_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fail_d    = fail_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSend;
          row_d     = '0;
          pass_d    = 1'b0;
          err_d     = ErrTimeout;
          fail_d    = '0;
          lfsr_load = 1'b1;
        end
      end
      StSend: begin
        lfsr_en = 1'b1;
        if (row_q == 6'd0) lane_d = lfsr[2:0];
        for (int i = 0; i < NumObs; i++) begin
          if (row_q == 6'((i + 1) * OBS_PERIOD)) obs_d[i] = {lfsr[2:0], obs_tile};
        end
        if (row_q == 6'(ROWS - 1)) begin
          state_d = StWait;
          wait_d  = '0;
          move_d  = 6'd1;
        end else begin
          row_d = row_q + 6'd1;
        end
      end
      StWait: begin
        // WAIT lasts TIMEOUT-1 cycles so done lands TIMEOUT cycles after the last row.
        if (!out_valid) begin
          if (wait_q == WaitW'(TIMEOUT - 2)) begin
            state_d = StDone;
            err_d   = ErrTimeout;
            fail_d  = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      StCheck: begin
        if (!out_valid) begin
          state_d = StDone;
          err_d   = ErrProtocol;
          fail_d  = move_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A move is judged in the cycle it arrives; any verdict is reported next cycle.
    if (out_valid && (state_q == StWait || state_q == StCheck)) begin
      lane_d = new_lane;
      if (move_err) begin
        state_d = StDone;
        err_d   = move_code;
        fail_d  = move_q;
      end else if (move_q == 6'(ROWS - 1)) begin
        state_d = StDone;
        pass_d  = 1'b1;
      end else begin
        state_d = StCheck;
        move_d  = move_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      move_q  <= '0;
      wait_q  <= '0;
      lane_q  <= '0;
      obs_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= ErrTimeout;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      move_q  <= move_d;
      wait_q  <= wait_d;
      lane_q  <= lane_d;
      obs_q   <= obs_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign bp_in_valid = (state_q == StSend);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign fail_row    = fail_q;

endmodule
